// File: rtl/mc_fifomem_pkg.sv
// Shared definitions for the multi-channel FIFO memory: channel-index width,
// pointer/count types and the parity helper.
package mc_fifomem_pkg;

    localparam int MC_ADDRSIZE = 4;

    typedef logic [MC_ADDRSIZE-1:0] ptr_t;
    typedef logic [MC_ADDRSIZE:0]   cnt_t;

    // A single channel still needs a 1-bit select so the port never collapses to zero width.
    function automatic int calc_chw(input int numch);
        return (numch <= 1) ? 1 : $clog2(numch);
    endfunction

    // Even parity; zero-extension does not change it, so words up to 64 bits are supported.
    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mc_fifomem_chctl.sv
// Per-channel queue bookkeeping: write/read pointers, occupancy count and
// registered full/empty/almost-full flags, driven by already-accepted enables.
module mc_fifomem_chctl
    import mc_fifomem_pkg::*;
#(
    parameter int ADDRSIZE     = MC_ADDRSIZE,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_wr_acc,
    input  logic                i_rd_acc,
    output logic [ADDRSIZE-1:0] o_wptr,
    output logic [ADDRSIZE-1:0] o_rptr,
    output logic [ADDRSIZE:0]   o_count,
    output logic                o_full,
    output logic                o_empty,
    output logic                o_afull
);

    localparam int              DEPTH   = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] C_DEPTH = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE:0] C_AFULL = (ADDRSIZE+1)'(DEPTH - AFULL_MARGIN);

    logic [ADDRSIZE-1:0] r_wptr;
    logic [ADDRSIZE-1:0] r_rptr;
    logic [ADDRSIZE:0]   r_count;
    logic [ADDRSIZE:0]   w_count_next;
    logic                r_full;
    logic                r_empty;
    logic                r_afull;

    always_comb begin
        w_count_next = r_count;
        if (i_wr_acc && !i_rd_acc) begin
            w_count_next = r_count + 1'b1;
        end else if (i_rd_acc && !i_wr_acc) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Flags are derived from the next count so they change on the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_afull <= 1'b0;
        end else begin
            if (i_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == C_DEPTH);
            r_empty <= (w_count_next == '0);
            r_afull <= (w_count_next >= C_AFULL);
        end
    end

    assign o_wptr  = r_wptr;
    assign o_rptr  = r_rptr;
    assign o_count = r_count;
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_afull = r_afull;

endmodule

// File: rtl/mc_fifomem.sv
// Multi-channel FIFO memory: one shared RAM split into NUMCH circular queues.
// Optional word parity is enabled by defining MC_FIFOMEM_PARITY_EN.
module mc_fifomem
    import mc_fifomem_pkg::*;
#(
    parameter int DATASIZE     = 8,
    parameter int ADDRSIZE     = 4,
    parameter int NUMCH        = 4,
    parameter int AFULL_MARGIN = 2,
    localparam int CHW         = calc_chw(NUMCH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wen,
    input  logic [CHW-1:0]                wch,
    input  logic [DATASIZE-1:0]           wdata,
    input  logic                          ren,
    input  logic [CHW-1:0]                rch,
    output logic [DATASIZE-1:0]           rdata,
    output logic                          rvalid,
    output logic [NUMCH-1:0]              full,
    output logic [NUMCH-1:0]              empty,
    output logic [NUMCH-1:0]              afull,
    output logic [NUMCH*(ADDRSIZE+1)-1:0] count,
    output logic                          wovf,
    output logic                          rudf,
    output logic                          perr
);

    localparam int DEPTH = 1 << ADDRSIZE;
    localparam int NCH2  = 1 << CHW;
    localparam int AW    = CHW + ADDRSIZE;
    localparam int CW    = ADDRSIZE + 1;
`ifdef MC_FIFOMEM_PARITY_EN
    localparam int MW    = DATASIZE + 1;
`else
    localparam int MW    = DATASIZE;
`endif

    logic [MW-1:0]       r_mem [NUMCH*DEPTH];
    logic [MW-1:0]       r_rword;
    logic                r_rvalid;
    logic                r_wovf;
    logic                r_rudf;

    logic [ADDRSIZE-1:0] w_wptr [NCH2];
    logic [ADDRSIZE-1:0] w_rptr [NCH2];
    logic [NCH2-1:0]     w_full_all;
    logic [NCH2-1:0]     w_empty_all;
    logic [NUMCH-1:0]    w_wr_en;
    logic [NUMCH-1:0]    w_rd_en;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [AW-1:0]       w_waddr;
    logic [AW-1:0]       w_raddr;
    logic [MW-1:0]       w_wword;

    // Unused channel slots look permanently full and empty, so an out-of-range
    // channel index is rejected by the same flag test as a real full/empty queue.
    assign w_wr_acc = wen && !w_full_all[wch];
    assign w_rd_acc = ren && !w_empty_all[rch];
    assign w_waddr  = {wch, w_wptr[wch]};
    assign w_raddr  = {rch, w_rptr[rch]};

    genvar gi;
    generate
        for (gi = 0; gi < NCH2; gi++) begin : g_slot
            if (gi < NUMCH) begin : g_ch
                logic [CW-1:0] w_count;
                logic          w_full;
                logic          w_empty;
                logic          w_afull;

                assign w_wr_en[gi] = w_wr_acc && (wch == CHW'(gi));
                assign w_rd_en[gi] = w_rd_acc && (rch == CHW'(gi));

                mc_fifomem_chctl #(
                    .ADDRSIZE     (ADDRSIZE),
                    .AFULL_MARGIN (AFULL_MARGIN)
                ) u_chctl (
                    .clk      (clk),
                    .rst      (rst),
                    .i_wr_acc (w_wr_en[gi]),
                    .i_rd_acc (w_rd_en[gi]),
                    .o_wptr   (w_wptr[gi]),
                    .o_rptr   (w_rptr[gi]),
                    .o_count  (w_count),
                    .o_full   (w_full),
                    .o_empty  (w_empty),
                    .o_afull  (w_afull)
                );

                assign w_full_all[gi]          = w_full;
                assign w_empty_all[gi]         = w_empty;
                assign full[gi]                = w_full;
                assign empty[gi]               = w_empty;
                assign afull[gi]               = w_afull;
                assign count[gi*CW +: CW]      = w_count;
            end else begin : g_pad
                assign w_wptr[gi]      = '0;
                assign w_rptr[gi]      = '0;
                assign w_full_all[gi]  = 1'b1;
                assign w_empty_all[gi] = 1'b1;
            end
        end
    endgenerate

`ifdef MC_FIFOMEM_PARITY_EN
    assign w_wword = {even_par(64'(wdata)), wdata};
    assign perr    = r_rvalid &&
                     (even_par(64'(r_rword[DATASIZE-1:0])) != r_rword[DATASIZE]);
`else
    assign w_wword = wdata;
    assign perr    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_waddr] <= w_wword;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rword  <= '0;
            r_rvalid <= 1'b0;
            r_wovf   <= 1'b0;
            r_rudf   <= 1'b0;
        end else begin
            if (w_rd_acc) begin
                r_rword <= r_mem[w_raddr];
            end
            r_rvalid <= w_rd_acc;
            r_wovf   <= wen && !w_wr_acc;
            r_rudf   <= ren && !w_rd_acc;
        end
    end

    assign rdata  = r_rword[DATASIZE-1:0];
    assign rvalid = r_rvalid;
    assign wovf   = r_wovf;
    assign rudf   = r_rudf;

endmodule

// File: tb/tb_mc_fifomem.sv
// Directed self-checking bench for mc_fifomem (default parameters; parity
// corruption check runs when MC_FIFOMEM_PARITY_EN is defined).
module tb_mc_fifomem;

    logic        clk;
    logic        rst;
    logic        wen;
    logic [1:0]  wch;
    logic [7:0]  wdata;
    logic        ren;
    logic [1:0]  rch;
    logic [7:0]  rdata;
    logic        rvalid;
    logic [3:0]  full;
    logic [3:0]  empty;
    logic [3:0]  afull;
    logic [19:0] count;
    logic        wovf;
    logic        rudf;
    logic        perr;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q3[$];
    logic [7:0] exp_d;

    mc_fifomem #(
        .DATASIZE     (8),
        .ADDRSIZE     (4),
        .NUMCH        (4),
        .AFULL_MARGIN (2)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .wen    (wen),
        .wch    (wch),
        .wdata  (wdata),
        .ren    (ren),
        .rch    (rch),
        .rdata  (rdata),
        .rvalid (rvalid),
        .full   (full),
        .empty  (empty),
        .afull  (afull),
        .count  (count),
        .wovf   (wovf),
        .rudf   (rudf),
        .perr   (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic w, input logic [1:0] wc, input logic [7:0] wd,
                        input logic r, input logic [1:0] rc);
        wen   = w;
        wch   = wc;
        wdata = wd;
        ren   = r;
        rch   = rc;
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
    endtask

    function automatic logic [4:0] cnt(input int c);
        return count[c*5 +: 5];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; wen = 1'b0; wch = '0; wdata = '0; ren = 1'b0; rch = '0;
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        rst = 1'b0;
        check("reset_empty", 32'(empty), 32'hF);
        check("reset_full", 32'(full), 32'h0);
        check("reset_afull", 32'(afull), 32'h0);
        check("reset_count", 32'(count), 32'h0);
        check("reset_rvalid", 32'(rvalid), 32'h0);
        check("reset_rdata", 32'(rdata), 32'h0);
        check("reset_wovf_rudf", {30'b0, wovf, rudf}, 32'h0);

        // ch2: four writes then four reads in order
        for (int i = 0; i < 4; i++) step(1, 2, 8'h11 + 8'(i), 0, 0);
        check("ch2_count_after_wr", 32'(cnt(2)), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 8'h00, 1, 2);
            check($sformatf("ch2_rd%0d_rvalid", i), 32'(rvalid), 32'd1);
            check($sformatf("ch2_rd%0d_rdata", i), 32'(rdata), 32'h11 + 32'(i));
            check($sformatf("ch2_rd%0d_count", i), 32'(cnt(2)), 32'd3 - 32'(i));
        end
        check("ch2_perr_clean", 32'(perr), 32'd0);
        check("ch2_empty", 32'(empty[2]), 32'd1);
        step(0, 0, 8'h00, 0, 0);
        check("rvalid_pulse_end", 32'(rvalid), 32'd0);

        // ch0: fill to 16, check almost-full threshold and overflow
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 8'hA0 + 8'(i), 0, 0);
            q0.push_back(8'hA0 + 8'(i));
            if (i >= 11) begin
                check($sformatf("ch0_afull_at%0d", i + 1), 32'(afull[0]), (i + 1 >= 14) ? 32'd1 : 32'd0);
                check($sformatf("ch0_full_at%0d", i + 1), 32'(full[0]), (i + 1 == 16) ? 32'd1 : 32'd0);
            end
        end
        step(1, 0, 8'hFF, 0, 0);
        check("ch0_ovf_wovf", 32'(wovf), 32'd1);
        check("ch0_ovf_count", 32'(cnt(0)), 32'd16);
        check("others_empty", 32'(empty), 32'hE);
        step(0, 0, 8'h00, 0, 0);
        check("wovf_pulse_end", 32'(wovf), 32'd0);

        // underflow on empty ch1
        step(0, 0, 8'h00, 1, 1);
        check("ch1_udf_rudf", 32'(rudf), 32'd1);
        check("ch1_udf_rvalid", 32'(rvalid), 32'd0);
        check("ch1_udf_rdata_hold", 32'(rdata), 32'h14);
        step(0, 0, 8'h00, 0, 0);
        check("rudf_pulse_end", 32'(rudf), 32'd0);

        // ch3: simultaneous write/read at count 5 for 20 cycles
        for (int i = 0; i < 5; i++) begin
            step(1, 3, 8'h30 + 8'(i), 0, 0);
            q3.push_back(8'h30 + 8'(i));
        end
        check("ch3_count5", 32'(cnt(3)), 32'd5);
        for (int i = 0; i < 20; i++) begin
            exp_d = q3.pop_front();
            q3.push_back(8'h40 + 8'(i));
            step(1, 3, 8'h40 + 8'(i), 1, 3);
            check($sformatf("ch3_wr_rd%0d_rdata", i), 32'(rdata), 32'(exp_d));
            check($sformatf("ch3_wr_rd%0d_count", i), 32'(cnt(3)), 32'd5);
        end

        // interleaved traffic between ch0 and ch1
        for (int k = 0; k < 8; k++) begin
            exp_d = q0.pop_front();
            q1.push_back(8'h50 + 8'(k));
            step(1, 1, 8'h50 + 8'(k), 1, 0);
            check($sformatf("il%0d_rd_ch0", k), 32'(rdata), 32'(exp_d));
            exp_d = q1.pop_front();
            q0.push_back(8'h60 + 8'(k));
            step(1, 0, 8'h60 + 8'(k), 1, 1);
            check($sformatf("il%0d_rd_ch1", k), 32'(rdata), 32'(exp_d));
        end
        check("il_count_ch0", 32'(cnt(0)), 32'd16);
        check("il_count_ch1", 32'(cnt(1)), 32'd0);
        check("il_count_ch3", 32'(cnt(3)), 32'd5);

        // reset asserted in the middle of traffic
        rst = 1'b1;
        step(1, 0, 8'h77, 1, 0);
        rst = 1'b0;
        check("midrst_empty", 32'(empty), 32'hF);
        check("midrst_count", 32'(count), 32'h0);
        check("midrst_rvalid", 32'(rvalid), 32'd0);
        step(0, 0, 8'h00, 0, 0);
        check("postrst_rvalid", 32'(rvalid), 32'd0);
        step(0, 0, 8'h00, 1, 0);
        check("postrst_rd_ch0_rudf", 32'(rudf), 32'd1);

`ifdef MC_FIFOMEM_PARITY_EN
        // ch1 slot 0 lives at physical address {1,0} = 16
        step(1, 1, 8'h5A, 0, 0);
        u_dut.r_mem[16][0] = ~u_dut.r_mem[16][0];
        step(0, 0, 8'h00, 1, 1);
        check("par_rvalid", 32'(rvalid), 32'd1);
        check("par_perr", 32'(perr), 32'd1);
        check("par_rdata", 32'(rdata), 32'h5B);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mc_fifomem.md
# mc_fifomem

Multi-channel, single-clock FIFO memory: one shared dual-port RAM partitioned into NUMCH independent circular queues, each with its own write/read pointers, occupancy count and full/empty/almost-full flags. Successor to the single-queue FIFO memory. It adds per-channel queue management, a registered read port with valid strobe, and overflow/underflow reporting. It sits between packet classifiers (writers) and per-channel schedulers (readers) where one RAM must serve several logical queues.

## Interface
- DATASIZE, 8, data word width
- ADDRSIZE, 4, per-channel address bits; per-channel depth DEPTH = 1<<ADDRSIZE
- NUMCH, 4, number of channels (1..16)
- AFULL_MARGIN, 2, afull asserts when count >= DEPTH-AFULL_MARGIN
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- wen  in  1  write request
- wch  in  CHW  write channel index, CHW = max(1,$clog2(NUMCH))
- wdata  in  DATASIZE  write data
- ren  in  1  read request
- rch  in  CHW  read channel index
- rdata  out  DATASIZE  read data, registered
- rvalid  out  1  rdata valid strobe
- full  out  NUMCH  per-channel full
- empty  out  NUMCH  per-channel empty
- afull  out  NUMCH  per-channel almost-full
- count  out  NUMCH*(ADDRSIZE+1)  per-channel occupancy, channel c at [c*(ADDRSIZE+1) +: ADDRSIZE+1]
- wovf  out  1  write-dropped pulse
- rudf  out  1  read-ignored pulse
- perr  out  1  parity error on returned word (see Configuration)

## Operation
- RAM holds NUMCH*DEPTH words; physical address = {ch, ptr}.
- Write accepted iff wen && wch<NUMCH && !full[wch]: mem[{wch,wptr[wch]}] <= wdata, wptr[wch]++ (wraps mod DEPTH).
- Read accepted iff ren && rch<NUMCH && !empty[rch]: rdata <= mem[{rch,rptr[rch]}], rptr[rch]++ (wraps).
- Rejected write (full or invalid channel): data dropped, no state change, wovf pulses. Rejected read: rudf pulses, rvalid stays 0, rdata holds.
- Acceptance is decided on flag state at the start of the cycle. A write to an empty channel does not enable a same-cycle read of that channel.
- Count update per channel: +1 write only, -1 read only, unchanged when both accepted on same channel or neither. Width ADDRSIZE+1, range 0..DEPTH.
- full = (count==DEPTH); empty = (count==0); afull = (count >= DEPTH-AFULL_MARGIN).
- Reads and writes on different channels are fully independent.
- Reset: all pointers and counts 0, empty all 1, full/afull 0, rvalid/wovf/rudf/perr 0, rdata 0. RAM contents not cleared. Reset mid-operation discards all queued data and any in-flight read; rvalid is 0 the cycle after reset.

## Timing
- Read latency 1: ren accepted at edge N gives rdata/rvalid valid after edge N; rvalid is a 1-cycle pulse per accepted read.
- Flags/count registered: updated at the edge that accepts the operation.
- Write-to-read: word written at edge N is readable by a request sampled at edge N+1, with data after edge N+1.
- wovf/rudf registered, asserted for the cycle after the rejected request.
- Back-to-back reads of one channel sustain 1 word/cycle.

## Configuration
- MC_FIFOMEM_PARITY_EN defined: RAM width DATASIZE+1, even parity of wdata stored on write. Parity is checked on read; perr pulses alongside rvalid on mismatch, and rdata is still delivered.
- Undefined: RAM width DATASIZE, no parity logic, perr tied 0.

## Structure
- Package mc_fifomem_pkg holds the CHW computation function, the pointer/count typedefs parameterised by ADDRSIZE, and the parity function.
- Sub-module mc_fifomem_chctl holds one channel's wptr/rptr/count/flags. It takes accepted write/read enables and outputs pointers and flags, and is generated NUMCH times. The top level owns the RAM, accept logic, read register and error pulses.

## Test plan
- Reset, then write 0x11..0x14 to ch2 and read ch2 four times -> rdata 0x11..0x14 in order, one cycle after each ren; count[2] goes 4 -> 0, empty[2]=1.
- Fill ch0 with 16 words (ADDRSIZE=4) -> full[0]=1 and afull[0] from count 14. A 17th write -> wovf pulse and count stays 16; other channels stay empty.
- Read empty ch1 -> rudf pulse, rvalid=0, rdata unchanged.
- With ch3 at count 5, write and read ch3 in the same cycle for 20 cycles -> count stays 5, pointers wrap, data order preserved.
- Interleave writes to ch0/ch1 and reads from ch1/ch0 on alternating cycles -> no cross-channel corruption. Assert rst mid-stream -> all empty, rvalid 0 next cycle.
- With MC_FIFOMEM_PARITY_EN defined, force-flip one stored bit via hierarchical access and read it -> perr=1 with rvalid.
